// File: rtl/updown_sched.sv
`default_nettype none
// ============================================================================
// updown_sched : two-requester round-robin scheduler driving a loadable
//                up/down counter (LOAD / UP-by-N / DOWN-by-N / NOP).
// Optional: define UPDOWN_SCHED_SAT_EN to saturate UP/DOWN instead of wrapping.
// Revision: 1.0
// ============================================================================
module updown_sched #(
  parameter int WIDTH = 4,
  parameter int STEPW = 4,
  localparam int ARGW = (WIDTH > STEPW) ? WIDTH : STEPW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [1:0]       cmd0,
  input  logic [ARGW-1:0]  arg0,
  input  logic             req1,
  input  logic [1:0]       cmd1,
  input  logic [ARGW-1:0]  arg1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic             sat,
  output logic             cnt_load,
  output logic             cnt_control,
  output logic [WIDTH-1:0] cnt_data_in,
  input  logic [WIDTH-1:0] cnt_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [1:0] CMD_LOAD = 2'b00;
  localparam logic [1:0] CMD_UP   = 2'b01;
  localparam logic [1:0] CMD_DOWN = 2'b10;

  state_e            state_q, state_d;
  logic              rr_last_q, rr_last_d;
  logic [1:0]        cmd_q, cmd_d;
  logic [ARGW-1:0]   arg_q, arg_d;
  logic              id_q, id_d;
  logic [STEPW-1:0]  rem_q, rem_d;
  logic              gnt0_q, gnt0_d;
  logic              gnt1_q, gnt1_d;
  logic              grant_id;
  logic              sat_hit;
`ifdef UPDOWN_SCHED_SAT_EN
  logic              sat_q, sat_d;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      rr_last_q <= 1'b1;
      cmd_q     <= 2'b11;
      arg_q     <= '0;
      id_q      <= 1'b0;
      rem_q     <= '0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
`ifdef UPDOWN_SCHED_SAT_EN
      sat_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      cmd_q     <= cmd_d;
      arg_q     <= arg_d;
      id_q      <= id_d;
      rem_q     <= rem_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
`ifdef UPDOWN_SCHED_SAT_EN
      sat_q     <= sat_d;
`endif
    end
  end

  // Saturation only matters on a cycle that would otherwise count.
`ifdef UPDOWN_SCHED_SAT_EN
  assign sat_hit = ((cmd_q == CMD_UP)   && (cnt_count == {WIDTH{1'b1}})) ||
                   ((cmd_q == CMD_DOWN) && (cnt_count == '0));
`else
  assign sat_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    rr_last_d   = rr_last_q;
    cmd_d       = cmd_q;
    arg_d       = arg_q;
    id_d        = id_q;
    rem_d       = rem_q;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    grant_id    = 1'b0;
`ifdef UPDOWN_SCHED_SAT_EN
    sat_d       = sat_q;
`endif
    // Park: reload the counter with its own value so it holds.
    cnt_load    = 1'b1;
    cnt_control = 1'b0;
    cnt_data_in = cnt_count;

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          grant_id  = (req0 && req1) ? ~rr_last_q : req1;
          rr_last_d = grant_id;
          id_d      = grant_id;
          cmd_d     = grant_id ? cmd1 : cmd0;
          arg_d     = grant_id ? arg1 : arg0;
          rem_d     = arg_d[STEPW-1:0];
          gnt0_d    = ~grant_id;
          gnt1_d    = grant_id;
`ifdef UPDOWN_SCHED_SAT_EN
          sat_d     = 1'b0;
`endif
          state_d   = EXEC;
        end
      end

      EXEC: begin
        case (cmd_q)
          CMD_LOAD: begin
            cnt_data_in = arg_q[WIDTH-1:0];
            state_d     = DONE;
          end
          CMD_UP, CMD_DOWN: begin
            if (rem_q == '0) begin
              state_d = DONE;
            end else if (sat_hit) begin
`ifdef UPDOWN_SCHED_SAT_EN
              sat_d   = 1'b1;
`endif
              state_d = DONE;
            end else begin
              cnt_load    = 1'b0;
              cnt_control = (cmd_q == CMD_UP);
              rem_d       = rem_q - 1'b1;
              if (rem_q == {{(STEPW-1){1'b0}}, 1'b1}) begin
                state_d = DONE;
              end
            end
          end
          default: begin
            state_d = DONE;
          end
        endcase
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign gnt0    = gnt0_q;
  assign gnt1    = gnt1_q;
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign done_id = id_q;
`ifdef UPDOWN_SCHED_SAT_EN
  assign sat     = sat_q;
`else
  assign sat     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_updown_sched.sv
`default_nettype none
// ============================================================================
// tb_updown_sched : directed self-checking bench for updown_sched with a
//                   behavioural loadable up/down counter attached.
// Revision: 1.0
// ============================================================================
module tb_updown_sched;

  localparam int WIDTH = 4;
  localparam int STEPW = 4;

  localparam logic [1:0] C_LOAD = 2'b00;
  localparam logic [1:0] C_UP   = 2'b01;
  localparam logic [1:0] C_DOWN = 2'b10;
  localparam logic [1:0] C_NOP  = 2'b11;

  logic             clk  = 1'b0;
  logic             rst  = 1'b0;
  logic             req0 = 1'b0;
  logic             req1 = 1'b0;
  logic [1:0]       cmd0 = 2'b11;
  logic [1:0]       cmd1 = 2'b11;
  logic [3:0]       arg0 = '0;
  logic [3:0]       arg1 = '0;
  logic             gnt0, gnt1, busy, done, done_id, sat;
  logic             cnt_load, cnt_control;
  logic [WIDTH-1:0] cnt_data_in;
  logic [WIDTH-1:0] cnt_q = '0;

  int n_cmp = 0;
  int n_bad = 0;

  updown_sched #(.WIDTH(WIDTH), .STEPW(STEPW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req0        (req0),
    .cmd0        (cmd0),
    .arg0        (arg0),
    .req1        (req1),
    .cmd1        (cmd1),
    .arg1        (arg1),
    .gnt0        (gnt0),
    .gnt1        (gnt1),
    .busy        (busy),
    .done        (done),
    .done_id     (done_id),
    .sat         (sat),
    .cnt_load    (cnt_load),
    .cnt_control (cnt_control),
    .cnt_data_in (cnt_data_in),
    .cnt_count   (cnt_q)
  );

  always #5 clk = ~clk;

  // Loadable up/down counter with no enable, owned by the scheduler.
  always @(posedge clk) begin
    if (cnt_load)         cnt_q <= cnt_data_in;
    else if (cnt_control) cnt_q <= cnt_q + 1'b1;
    else                  cnt_q <= cnt_q - 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Issue one command from a requester (called at a negedge while idle) and
  // check grant, EXEC length, counting cycles, completion and final count.
  task automatic run_cmd(input int who, input logic [1:0] c, input logic [3:0] a,
                         input int exp_exec, input int exp_steps, input logic exp_dir,
                         input logic [3:0] exp_cnt, input logic exp_sat);
    int n_exec;
    int n_step;
    int guard;
    if (who == 0) begin req0 = 1'b1; cmd0 = c; arg0 = a; end
    else          begin req1 = 1'b1; cmd1 = c; arg1 = a; end
    @(negedge clk);
    check("gnt", {30'd0, gnt1, gnt0}, (who == 0) ? 32'd1 : 32'd2);
    req0 = 1'b0;
    req1 = 1'b0;
    n_exec = 0;
    n_step = 0;
    guard  = 0;
    while (!done && guard < 40) begin
      n_exec++;
      if (!cnt_load && (cnt_control == exp_dir)) n_step++;
      guard++;
      @(negedge clk);
    end
    check("done_seen", {31'd0, done}, 32'd1);
    check("exec_cycles", n_exec, exp_exec);
    check("count_steps", n_step, exp_steps);
    check("done_id", {31'd0, done_id}, who);
    check("sat", {31'd0, sat}, {31'd0, exp_sat});
    check("count", {28'd0, cnt_q}, {28'd0, exp_cnt});
    @(negedge clk);
    check("idle_after_done", {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    logic [3:0] base;
    logic [3:0] exp4;
    int         guard;
    logic       saw_done;

    #2;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
    check("rst_done", {30'd0, done, done_id}, 32'd0);
    check("rst_sat", {31'd0, sat}, 32'd0);
    check("rst_park", {30'd0, cnt_load, cnt_control}, 32'd2);
    check("rst_park_data", {28'd0, cnt_data_in}, {28'd0, cnt_q});
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // LOAD 5 then hold through idle cycles
    run_cmd(0, C_LOAD, 4'd5, 1, 0, 1'b0, 4'd5, 1'b0);
    repeat (10) @(negedge clk);
    check("park_hold", {28'd0, cnt_q}, 32'd5);
    check("park_load", {31'd0, cnt_load}, 32'd1);

    run_cmd(1, C_UP, 4'd3, 3, 3, 1'b1, 4'd8, 1'b0);

    // Simultaneous requests twice: rr_last=1 after req1, so 0 then 1.
    for (int k = 0; k < 2; k++) begin
      req0 = 1'b1; cmd0 = C_NOP;
      req1 = 1'b1; cmd1 = C_NOP;
      @(negedge clk);
      check("rr_gnt", {30'd0, gnt1, gnt0}, (k == 0) ? 32'd1 : 32'd2);
      req0 = 1'b0;
      req1 = 1'b0;
      guard = 0;
      while (!done && guard < 40) begin guard++; @(negedge clk); end
      check("rr_done_id", {31'd0, done_id}, k);
      @(negedge clk);
    end
    check("nop_count", {28'd0, cnt_q}, 32'd8);

    // Lone requester wins even though it was served last.
    run_cmd(1, C_NOP, 4'd0, 1, 0, 1'b0, 4'd8, 1'b0);

    run_cmd(0, C_LOAD, 4'd2, 1, 0, 1'b0, 4'd2, 1'b0);
`ifdef UPDOWN_SCHED_SAT_EN
    run_cmd(1, C_DOWN, 4'd4, 3, 2, 1'b0, 4'd0, 1'b1);
    base = 4'd0;
`else
    run_cmd(1, C_DOWN, 4'd4, 4, 4, 1'b0, 4'd14, 1'b0);
    base = 4'd14;
`endif

    // UP by 0: one parked EXEC cycle; sat cleared by the new grant.
    run_cmd(0, C_UP, 4'd0, 1, 0, 1'b1, base, 1'b0);

    // Reset in the middle of UP by 10 after 4 steps.
    req1 = 1'b1; cmd1 = C_UP; arg1 = 4'd10;
    @(negedge clk);
    check("mid_gnt", {30'd0, gnt1, gnt0}, 32'd2);
    req1 = 1'b0;
    repeat (4) @(negedge clk);
    rst  = 1'b0;
    exp4 = base + 4'd4;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_gnt_done", {29'd0, gnt1, gnt0, done}, 32'd0);
    check("mid_rst_park", {30'd0, cnt_load, cnt_control}, 32'd2);
    check("mid_rst_count", {28'd0, cnt_q}, {28'd0, exp4});
    check("mid_rst_data", {28'd0, cnt_data_in}, {28'd0, exp4});
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      saw_done = saw_done | done;
    end
    check("mid_rst_no_done", {31'd0, saw_done}, 32'd0);
    check("mid_rst_hold", {28'd0, cnt_q}, {28'd0, exp4});
    rst = 1'b1;
    @(negedge clk);

    run_cmd(0, C_LOAD, 4'd9, 1, 0, 1'b0, 4'd9, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
